// File: rtl/rv32_wb_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rv32_wb_pkg                                                         |
// | Shared types for the register-file writeback path.                 |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
package rv32_wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | wb_fifo                                                             |
// | Circular buffer of pending load writebacks; DEPTH is a power of 2.  |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module wb_fifo
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_level == C_DEPTH);
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | regfile_wb_arbiter                                                  |
// | Shares the register-file write port between ALU and buffered LSU    |
// | results, bounds ALU starvation, tracks in-flight loads for decode.  |
// | Optional: WB_LSU_BYPASS_EN grants an LSU result directly when the   |
// | ALU is idle and the FIFO is empty.                                  |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module regfile_wb_arbiter
  import rv32_wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_AW-1:0]      lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic                   issue_load,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic [REG_AW-1:0]      chk_rs1,
  input  logic [REG_AW-1:0]      chk_rs2,
  output logic                   stall,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic                   wb_valid,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

  logic              w_full;
  logic              w_empty;
  wb_entry_t         w_head;
  logic              w_alu_grant;
  logic              w_pop;
  logic              w_push;
  logic              w_bypass;
  wb_src_t           w_src;
  wb_entry_t         w_entry;

  logic [CW-1:0]     r_starve_cnt;
  logic [31:0]       r_pend;
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;
  wb_src_t           r_wb_src;

`ifdef WB_LSU_BYPASS_EN
  assign w_bypass = !alu_valid && w_empty && lsu_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign alu_ready   = (r_starve_cnt != C_STARVE_MAX);
  assign lsu_ready   = !w_full;
  assign w_alu_grant = alu_valid && alu_ready;
  assign w_pop       = !w_alu_grant && !w_empty;
  assign w_push      = lsu_valid && lsu_ready && !w_bypass;

  assign stall = r_pend[chk_rs1] | r_pend[chk_rs2] | (issue_load & r_pend[issue_rd]);

  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry ({lsu_rd, lsu_data}),
    .pop        (w_pop),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .level      (fifo_level)
  );

  always_comb begin
    w_src   = SRC_NONE;
    w_entry = '0;
    if (w_alu_grant) begin
      w_src   = SRC_ALU;
      w_entry = '{rd: alu_rd, data: alu_data};
    end else if (w_pop) begin
      w_src   = SRC_LSU;
      w_entry = w_head;
    end else if (w_bypass) begin
      w_src   = SRC_LSU;
      w_entry = '{rd: lsu_rd, data: lsu_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_empty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (w_alu_grant) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_src   <= SRC_NONE;
    end else begin
      r_wb_valid <= (w_src != SRC_NONE) && (w_entry.rd != '0);
      r_wb_src   <= w_src;
      if (w_src != SRC_NONE) begin
        r_wb_rd   <= w_entry.rd;
        r_wb_data <= w_entry.data;
      end
    end
  end

  // A fresh issue takes priority over a retiring load to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (r_wb_valid && (r_wb_src == SRC_LSU)) r_pend[r_wb_rd] <= 1'b0;
      if (issue_load && (issue_rd != '0) && !stall) r_pend[issue_rd] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_regfile_wb_arbiter                                               |
// | Directed and randomized bench with an in-bench writeback model.     |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        issue_load = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic        stall;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [2:0]  fifo_level;

  regfile_wb_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_load(issue_load), .issue_rd(issue_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .stall(stall), .wb_rd(wb_rd), .wb_data(wb_data), .wb_valid(wb_valid),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: queued load results, pending loads, ALU streak, output register.
  logic [36:0] m_q[$];
  bit          m_pend[32];
  int          m_streak;
  bit          m_wbv;
  bit          m_wb_lsu;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_streak = 0;
    m_wbv    = 1'b0;
    m_wb_lsu = 1'b0;
    m_wbrd   = '0;
    m_wbdata = '0;
  endtask

  task automatic idle();
    alu_valid  = 1'b0; lsu_valid = 1'b0; issue_load = 1'b0;
    alu_rd     = '0;   lsu_rd    = '0;   issue_rd   = '0;
    chk_rs1    = '0;   chk_rs2   = '0;
  endtask

  // Entered at posedge+1 with inputs applied; compares, advances the model, returns at next posedge+1.
  task automatic tick();
    bit          alu_rdy, agrant, pop, push, byp, stl;
    logic [36:0] head;
    #1;
    alu_rdy = (m_streak < STARVE_MAX);
    stl     = m_pend[chk_rs1] | m_pend[chk_rs2] | (issue_load & m_pend[issue_rd]);
    chk("fifo_level", fifo_level, m_q.size());
    chk("lsu_ready", lsu_ready, m_q.size() < DEPTH);
    chk("alu_ready", alu_ready, alu_rdy);
    chk("stall", stall, stl);
    chk("wb_valid", wb_valid, m_wbv);
    if (m_wbv) begin
      chk("wb_rd", wb_rd, m_wbrd);
      chk("wb_data", wb_data, m_wbdata);
    end
    agrant = alu_valid && alu_rdy;
    pop    = !agrant && (m_q.size() != 0);
`ifdef WB_LSU_BYPASS_EN
    byp    = !alu_valid && (m_q.size() == 0) && lsu_valid;
`else
    byp    = 1'b0;
`endif
    push   = lsu_valid && (m_q.size() < DEPTH) && !byp;
    if (m_wbv && m_wb_lsu) m_pend[m_wbrd] = 1'b0;
    if (issue_load && issue_rd != 0 && !stl) m_pend[issue_rd] = 1'b1;
    if (m_q.size() == 0 || pop) m_streak = 0;
    else if (agrant)            m_streak++;
    if (agrant) begin
      m_wbv = (alu_rd != 0); m_wbrd = alu_rd; m_wbdata = alu_data; m_wb_lsu = 1'b0;
    end else if (pop) begin
      head  = m_q.pop_front();
      m_wbv = (head[36:32] != 0); m_wbrd = head[36:32]; m_wbdata = head[31:0]; m_wb_lsu = 1'b1;
    end else if (byp) begin
      m_wbv = (lsu_rd != 0); m_wbrd = lsu_rd; m_wbdata = lsu_data; m_wb_lsu = 1'b1;
    end else begin
      m_wbv = 1'b0; m_wb_lsu = 1'b0;
    end
    if (push) m_q.push_back({lsu_rd, lsu_data});
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_rd", wb_rd, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset alu_ready", alu_ready, 1);
    chk("reset lsu_ready", lsu_ready, 1);
    chk("reset stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick(); idle();
    chk("alu wb_valid", wb_valid, 1);
    chk("alu wb_rd", wb_rd, 5);
    chk("alu wb_data", wb_data, 32'h1234);
    chk("alu fifo untouched", fifo_level, 0);
    tick();

    // Load path: ALU x0 write occupies the port so the load is buffered in either build
    issue_load = 1'b1; issue_rd = 5'd7; chk_rs1 = 5'd7;
    tick(); issue_load = 1'b0; #1;
    chk("load stall set", stall, 1);
    tick(); tick(); tick();
    alu_valid = 1'b1; alu_rd = 5'd0; lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEADBEEF;
    tick(); alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk("load wb_valid", wb_valid, 1);
    chk("load wb_rd", wb_rd, 7);
    chk("load wb_data", wb_data, 32'hDEADBEEF);
    chk("load stall still set", stall, 1);
    tick(); #1;
    chk("load stall cleared", stall, 0);
    idle(); tick();

    // Starvation bound: one queued load, continuous ALU
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAAAA;
    tick(); lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_rd = 5'(2 + i); alu_data = 32'hA1 + i;
      tick();
    end
    #1;
    chk("starve alu_ready held", alu_ready, 0);
    tick();
    chk("starve lsu wb_valid", wb_valid, 1);
    chk("starve lsu wb_rd", wb_rd, 10);
    chk("starve lsu wb_data", wb_data, 32'hAAAA);

    // Fill the FIFO while the ALU is busy
    for (int i = 0; i < 4; i++) begin
      alu_rd = 5'(20 + i); alu_data = 32'hB0 + i;
      lsu_valid = 1'b1; lsu_rd = 5'(11 + i); lsu_data = 32'hC0 + i;
      tick();
    end
    chk("full level", fifo_level, 4);
    chk("full lsu_ready", lsu_ready, 0);
    chk("full alu_ready", alu_ready, 0);
    lsu_rd = 5'd15; lsu_data = 32'hC4;
    tick();
    chk("full pop blocks push", fifo_level, 3);
    alu_valid = 1'b0;
    tick();
    lsu_rd = 5'd16; lsu_data = 32'hC5;
    tick(); tick();
    chk("push+pop level held", fifo_level, 3);
    idle();
    for (int i = 0; i < DEPTH + 2; i++) tick();

    // x0 load result is consumed silently
    alu_valid = 1'b1; alu_rd = 5'd0; lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    tick(); idle();
    tick();
    chk("x0 wb_valid", wb_valid, 0);
    chk("x0 fifo drained", fifo_level, 0);

    // Asynchronous reset with work in flight
    issue_load = 1'b1; issue_rd = 5'd20; chk_rs1 = 5'd20;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(21 + i); lsu_data = 32'hD0 + i;
      tick(); issue_load = 1'b0;
    end
    alu_valid = 1'b0; lsu_valid = 1'b0; #1;
    chk("pre-reset level", fifo_level, 3);
    chk("pre-reset stall", stall, 1);
    #1 rst = 1'b1;
    #1;
    chk("async reset level", fifo_level, 0);
    chk("async reset wb_valid", wb_valid, 0);
    chk("async reset stall", stall, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; idle();
    tick();

`ifdef WB_LSU_BYPASS_EN
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999;
    tick(); idle();
    chk("bypass wb_valid", wb_valid, 1);
    chk("bypass wb_rd", wb_rd, 9);
    chk("bypass level", fifo_level, 0);
    tick();
`endif

    // Randomized traffic at several ALU pressures
    for (int seg = 0; seg < 4; seg++) begin
      int p;
      p = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 10 : 70;
      for (int c = 0; c < 500; c++) begin
        alu_valid  = ($urandom_range(99) < p);
        alu_rd     = 5'($urandom_range(7));
        alu_data   = $urandom;
        lsu_valid  = ($urandom_range(99) < 50);
        lsu_rd     = 5'($urandom_range(7));
        lsu_data   = $urandom;
        issue_load = ($urandom_range(99) < 25);
        issue_rd   = 5'($urandom_range(7));
        chk_rs1    = 5'($urandom_range(7));
        chk_rs2    = 5'($urandom_range(7));
        tick();
      end
    end
    idle();
    for (int i = 0; i < DEPTH + 2; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
